mem_arbiter: RTL

- Shares the single-port synchronous memory (32-bit words, 8-bit word address, 1-cycle registered read, write on clock edge) between two requesters: the instruction-fetch port (IF, read-only) and the load/store port (LS, read/write).
- Arbitrates one access per cycle, drives the memory control and address/data inputs, and routes the read data back to the port that issued the read, tagged with a 1-cycle-delayed response valid.
- Sits between the core pipeline and the memory instance.

---
 rtl/mem_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory: IF (read-only)
// and LS (read/write) share one access per cycle; read data returns one cycle later.
module mem_arbiter #(
  parameter int W        = 32,
  parameter int D        = 8,
  parameter int ARB_MODE = 0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_if_req,
  input  logic [D-1:0] i_if_addr,
  output logic         o_if_gnt,
  output logic         o_if_rsp_valid,
  output logic [W-1:0] o_if_rdata,
  input  logic         i_ls_req,
  input  logic         i_ls_we,
  input  logic [D-1:0] i_ls_addr,
  input  logic [W-1:0] i_ls_wdata,
  output logic         o_ls_gnt,
  output logic         o_ls_rsp_valid,
  output logic [W-1:0] o_ls_rdata,
  output logic [D-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  output logic         o_mem_read,
  output logic         o_mem_write,
  input  logic [W-1:0] i_mem_rdata
);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  owner_t     rr_last;
  owner_t     rr_next;
  logic [1:0] rsp_tag;
  logic [1:0] rsp_tag_next;
  logic       if_gnt;
  logic       ls_gnt;

  // Grant / response-owner register stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_last <= OWN_IF;
      rsp_tag <= 2'b00;
    end else begin
      rr_last <= rr_next;
      rsp_tag <= rsp_tag_next;
    end
  end

  // Grants are forced low while reset is held so the memory sees no access.
  always_comb begin
    if_gnt       = 1'b0;
    ls_gnt       = 1'b0;
    rr_next      = rr_last;
    rsp_tag_next = 2'b00;
    if (i_rst_n) begin
      if (i_if_req && i_ls_req) begin
        if (ARB_MODE == 1 || rr_last == OWN_IF) ls_gnt = 1'b1;
        else                                    if_gnt = 1'b1;
      end else begin
        if_gnt = i_if_req;
        ls_gnt = i_ls_req;
      end
    end
    if (if_gnt)      rr_next = OWN_IF;
    else if (ls_gnt) rr_next = OWN_LS;
    rsp_tag_next = {ls_gnt & ~i_ls_we, if_gnt};
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_mem_addr  = if_gnt ? i_if_addr : i_ls_addr;
  assign o_mem_wdata = i_ls_wdata;
  assign o_mem_read  = if_gnt | (ls_gnt & ~i_ls_we);
  assign o_mem_write = ls_gnt & i_ls_we;

  // Memory output is already registered, so read data is a passthrough.
  assign o_if_rsp_valid = rsp_tag[0];
  assign o_ls_rsp_valid = rsp_tag[1];
  assign o_if_rdata     = i_mem_rdata;
  assign o_ls_rdata     = i_mem_rdata;

endmodule
